// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared definitions for the memory FIFO controller and its memory instance.
// Holds the default geometry (word width, address width, depth) so the
// controller and the single-port memory are always built to the same size,
// and the controller state encoding, which is kept as plain constants so
// older code that compares against raw 2-bit values keeps working.
package mem_fifo_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 6;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_RAM_DEPTH  = 8;

   localparam logic [1:0] ST_IDLE     = 2'd0;  // output register empty, no read in flight
   localparam logic [1:0] ST_RD_WAIT  = 2'd1;  // read issued on the previous edge
   localparam logic [1:0] ST_OUT_HOLD = 2'd2;  // output register holds a valid word

endpackage

// File: rtl/mem_fifo_ptrs.sv
// Write/read pointers and occupancy counter for the memory FIFO.
// Ports:
//   clk       - clock, all state on posedge
//   rst       - synchronous active-high reset
//   wr_inc_i  - one word written to memory this cycle
//   rd_inc_i  - one read issued to memory this cycle
//   wr_ptr_o  - next memory address to write
//   rd_ptr_o  - next memory address to read
//   count_o   - words held in memory (0..RAM_DEPTH)
//   full_o    - count_o == RAM_DEPTH
//   empty_o   - count_o == 0
module mem_fifo_ptrs #(
   parameter int ADDR_WIDTH = 3,
   parameter int RAM_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_inc_i,
   input  logic                  rd_inc_i,
   output logic [ADDR_WIDTH-1:0] wr_ptr_o,
   output logic [ADDR_WIDTH-1:0] rd_ptr_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;

   // Pointers are exactly ADDR_WIDTH bits wide, so the increment wraps
   // naturally at RAM_DEPTH (which is 2**ADDR_WIDTH).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_inc_i) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_inc_i) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_inc_i, rd_inc_i})
         2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_ptr_o = wr_ptr_q;
   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;
   assign full_o   = (count_q == (ADDR_WIDTH+1)'(RAM_DEPTH));
   assign empty_o  = (count_q == '0);

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a single-port storage memory.
// Accepts pushes and delivers pops over ready/valid handshakes and turns
// them into at most one memory command per cycle (never read and write
// together). A popped word is held in a registered output stage.
// Ports:
//   clk, RESET                 - clock and synchronous active-high reset
//   in_data/in_valid/in_ready  - push side
//   out_data/out_valid/out_ready - pop side (out_data registered)
//   full, empty, count         - memory occupancy (output register excluded)
//   mem_address/mem_data/mem_write/mem_read - commands to the memory
//   mem_data_out/mem_valid_out/mem_err      - responses from the memory
//   err                        - sticky protocol error, cleared by RESET
module mem_fifo_ctrl
   import mem_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
   input  logic                  clk,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  mem_valid_out,
   input  logic                  mem_err,
   output logic                  err
);

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  err_q, err_d;
   logic                  rd_issue, wr_issue;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;

   // A read is launched whenever the output stage is (or is about to be)
   // free and memory holds data. It wins the single memory port over a push.
   assign rd_issue = !RESET && !empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_OUT_HOLD) && out_ready));
   // RESET gating keeps every memory command low while reset is held.
   assign in_ready = !RESET && !full && !rd_issue;
   assign wr_issue = in_valid && in_ready;

   assign mem_read    = rd_issue;
   assign mem_write   = wr_issue;
   assign mem_address = RESET ? '0 : (rd_issue ? rd_ptr : wr_ptr);
   assign mem_data    = in_data;

   mem_fifo_ptrs #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAM_DEPTH  (RAM_DEPTH)
   ) u_ptrs (
      .clk      (clk),
      .rst      (RESET),
      .wr_inc_i (wr_issue),
      .rd_inc_i (rd_issue),
      .wr_ptr_o (wr_ptr),
      .rd_ptr_o (rd_ptr),
      .count_o  (count),
      .full_o   (full),
      .empty_o  (empty)
   );

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      err_d       = err_q | mem_err;
      case (state_q)
         ST_IDLE: begin
            if (rd_issue) state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            // Memory registered its data on the previous edge, so a write
            // issued this cycle cannot disturb what is captured here.
            out_data_d  = mem_data_out;
            out_valid_d = 1'b1;
            state_d     = ST_OUT_HOLD;
            if (!mem_valid_out) err_d = 1'b1;
         end
         ST_OUT_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = rd_issue ? ST_RD_WAIT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

endmodule
